// File: rtl/dmem_arbiter_if.sv
// Word-request channel between one requester (core or debug loader) and dmem_arbiter.
// The requester holds req and its payload stable until it sees ack.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, err, rdata);
    modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the data memory: IDLE -> ACCESS -> ACK, one access per 3 clocks.
// Out-of-range word addresses are flagged at grant time and never reach the memory.
module dmem_arbiter #(
    parameter int DEPTH    = 64,
    parameter int PRIORITY = 0
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave a,
    dmem_arbiter_if.slave b,
    output logic          mem_we,
    output logic          mem_re,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]        req;
    logic [1:0]        ack;
    logic [1:0]        err;
    logic [1:0][31:0]  rdata;

    logic              start;
    logic              gnt_next;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;

    logic              gnt_reg;
    logic              last_gnt_reg;
    logic              we_reg;
    logic              err_reg;
    logic [31:0]       addr_reg;
    logic [31:0]       wdata_reg;

    assign req   = {b.req, a.req};
    assign start = (state_reg == IDLE) && (req != 2'b00);

    // Winner index: 0 = A, 1 = B. A tie goes to A under fixed priority,
    // otherwise to the port that was not granted last.
    always_comb begin
        gnt_next = 1'b0;
        if (req == 2'b10) begin
            gnt_next = 1'b1;
        end else if (req == 2'b11) begin
            gnt_next = (PRIORITY != 0) ? 1'b0 : ~last_gnt_reg;
        end
    end

    assign sel_we    = gnt_next ? b.we    : a.we;
    assign sel_addr  = gnt_next ? b.addr  : a.addr;
    assign sel_wdata = gnt_next ? b.wdata : a.wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req != 2'b00) state_next = ACCESS;
            ACCESS:  state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // last_gnt resets to B so that A takes the very first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_reg      <= 1'b0;
            last_gnt_reg <= 1'b1;
            we_reg       <= 1'b0;
            err_reg      <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
        end else if (start) begin
            gnt_reg      <= gnt_next;
            last_gnt_reg <= gnt_next;
            we_reg       <= sel_we;
            err_reg      <= (sel_addr >= 32'(DEPTH));
            addr_reg     <= sel_addr;
            wdata_reg    <= sel_wdata;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ack       = 2'b00;
        err       = 2'b00;
        busy      = (state_reg != IDLE);
        if (state_reg == ACCESS) begin
            mem_we    = we_reg & ~err_reg;
            mem_re    = ~we_reg & ~err_reg;
            mem_addr  = addr_reg;
            mem_wdata = wdata_reg;
        end
        if (state_reg == ACK) begin
            ack[gnt_reg] = 1'b1;
            err[gnt_reg] = err_reg;
        end
    end

    // Each port keeps its last read data until its own next completion.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [31:0] rdata_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_reg <= '0;
                end else if ((state_reg == ACCESS) && (gnt_reg == 1'(gi))) begin
                    rdata_reg <= mem_re ? mem_rdata : '0;
                end
            end
            assign rdata[gi] = rdata_reg;
        end
    endgenerate

    assign a.ack   = ack[0];
    assign a.err   = err[0];
    assign a.rdata = rdata[0];
    assign b.ack   = ack[1];
    assign b.err   = err[1];
    assign b.rdata = rdata[1];
endmodule
